cdb_write_scheduler: RTL

- Buffers completed results from the integer ALU and the branch ALU.
- Grants exactly one of them per cycle onto the common data bus (CDB), which broadcasts to the reservation stations and the ROB.
- Each requester has a small FIFO and a registered credit signal. A unit can finish while the bus is busy, and the unit stalls only when its FIFO is full.
- Arbitration is round-robin. A branch result flagged as a mispredict overrides it, so redirects reach the bus early.

---
 rtl/cdb_pkg.sv | 28 ++
 rtl/cdb_write_scheduler_if.sv | 43 ++++
 rtl/cdb_req_fifo.sv | 67 ++++++
 rtl/cdb_write_scheduler.sv | 137 +++++++++++++
 4 files changed

// File: rtl/cdb_pkg.sv
// Shared types for the CDB write scheduler: bus widths, the broadcast
// payload bundle and the grant encoding used by the arbiter.
package cdb_pkg;

    localparam int WIDTH          = 31;
    localparam int ROB            = 2;
    localparam int CONTROL        = 6;
    localparam int DEPTH          = 2;
    localparam int MISPREDICT_BIT = CONTROL;

    typedef struct packed {
        logic [ROB:0]     rob;
        logic [WIDTH:0]   result;
        logic             isBranch;
        logic [WIDTH:0]   address;
        logic [CONTROL:0] control;
    } cdb_payload_t;

    typedef enum logic {
        GRANT_ALU    = 1'b0,
        GRANT_BRANCH = 1'b1
    } grant_e;

    function automatic logic is_mispredict(input cdb_payload_t p);
        return p.isBranch & p.control[MISPREDICT_BIT];
    endfunction

endpackage

// File: rtl/cdb_write_scheduler_if.sv
// Requester-side and broadcast-side signals of the CDB write scheduler.
// slave: scheduler view; master: driver/observer view (ALU, branch, commit).
interface cdb_write_scheduler_if;
    import cdb_pkg::*;

    logic             aluValid;
    logic [ROB:0]     aluRob;
    logic [WIDTH:0]   aluResult;
    logic             branchValid;
    logic [ROB:0]     branchRob;
    logic [WIDTH:0]   branchResult;
    logic [WIDTH:0]   branchAddress;
    logic [CONTROL:0] branchControl;
    logic             flush;

    logic             aluAvailable;
    logic             branchAvailable;
    logic             cdbValid;
    logic [ROB:0]     cdbRob;
    logic [WIDTH:0]   cdbResult;
    logic             cdbIsBranch;
    logic [WIDTH:0]   cdbAddress;
    logic [CONTROL:0] cdbControl;

    modport slave (
        input  aluValid, aluRob, aluResult,
        input  branchValid, branchRob, branchResult,
        input  branchAddress, branchControl, flush,
        output aluAvailable, branchAvailable,
        output cdbValid, cdbRob, cdbResult,
        output cdbIsBranch, cdbAddress, cdbControl
    );

    modport master (
        output aluValid, aluRob, aluResult,
        output branchValid, branchRob, branchResult,
        output branchAddress, branchControl, flush,
        input  aluAvailable, branchAvailable,
        input  cdbValid, cdbRob, cdbResult,
        input  cdbIsBranch, cdbAddress, cdbControl
    );

endinterface

// File: rtl/cdb_req_fifo.sv
// Per-requester result FIFO. Ports: push/data write, pop, clear (flush),
// head/empty read side, available = registered free-entry credit.
module cdb_req_fifo #(
    parameter int  DEPTH = 2,
    parameter type T     = logic
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  T     data,
    input  logic pop,
    input  logic clear,
    output T     head,
    output logic empty,
    output logic available
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    T               mem [DEPTH];
    logic [PW-1:0]  wptr;
    logic [PW-1:0]  rptr;
    logic [CW-1:0]  count;
    logic           do_push;
    logic           do_pop;

    // Credit comes only from the registered count.
    assign available = (count < CW'(DEPTH));
    assign empty     = (count == '0);
    assign head      = mem[rptr];

    assign do_push = push & available;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem[wptr] <= data;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (clear) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + PW'(1);
            end
            if (do_pop) begin
                rptr <= rptr + PW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cdb_write_scheduler.sv
// Buffers ALU and branch results and grants one per cycle onto the CDB.
// Ports: clk, globalReset (async active-low), bus (requesters + CDB).
module cdb_write_scheduler
    import cdb_pkg::*;
#(
    parameter int FIFO_DEPTH = DEPTH
) (
    input  logic                  clk,
    input  logic                  globalReset,
    cdb_write_scheduler_if.slave  bus
);

    cdb_payload_t alu_in;
    cdb_payload_t br_in;
    cdb_payload_t alu_head;
    cdb_payload_t br_head;
    cdb_payload_t cdb;

    logic   alu_empty;
    logic   br_empty;
    logic   alu_push;
    logic   br_push;
    logic   grant_alu;
    logic   grant_br;
    logic   req_alu;
    logic   req_br;
    logic   br_mis;

    grant_e last_grant;
    grant_e last_grant_next;

    always_comb begin
        alu_in        = '0;
        alu_in.rob    = bus.aluRob;
        alu_in.result = bus.aluResult;
    end

    always_comb begin
        br_in          = '0;
        br_in.rob      = bus.branchRob;
        br_in.result   = bus.branchResult;
        br_in.isBranch = 1'b1;
        br_in.address  = bus.branchAddress;
        br_in.control  = bus.branchControl;
    end

    assign alu_push = bus.aluValid & ~bus.flush;
    assign br_push  = bus.branchValid & ~bus.flush;

    cdb_req_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (cdb_payload_t)
    ) u_alu_fifo (
        .clk       (clk),
        .rst_n     (globalReset),
        .push      (alu_push),
        .data      (alu_in),
        .pop       (grant_alu),
        .clear     (bus.flush),
        .head      (alu_head),
        .empty     (alu_empty),
        .available (bus.aluAvailable)
    );

    cdb_req_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (cdb_payload_t)
    ) u_br_fifo (
        .clk       (clk),
        .rst_n     (globalReset),
        .push      (br_push),
        .data      (br_in),
        .pop       (grant_br),
        .clear     (bus.flush),
        .head      (br_head),
        .empty     (br_empty),
        .available (bus.branchAvailable)
    );

    assign req_alu = ~alu_empty;
    assign req_br  = ~br_empty;
    assign br_mis  = is_mispredict(br_head);

    // Mispredicting branch heads jump the round-robin order.
    always_comb begin
        grant_alu = 1'b0;
        grant_br  = 1'b0;
        unique case (1'b1)
            (!req_alu && !req_br): ;
            (req_alu && !req_br):  grant_alu = 1'b1;
            (!req_alu && req_br):  grant_br  = 1'b1;
            (req_alu && req_br && br_mis):
                grant_br = 1'b1;
            (req_alu && req_br && !br_mis && last_grant == GRANT_ALU):
                grant_br = 1'b1;
            (req_alu && req_br && !br_mis && last_grant == GRANT_BRANCH):
                grant_alu = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        last_grant_next = last_grant;
        if (!bus.flush) begin
            if (grant_br) begin
                last_grant_next = GRANT_BRANCH;
            end else if (grant_alu) begin
                last_grant_next = GRANT_ALU;
            end
        end
    end

    always_ff @(posedge clk or negedge globalReset) begin
        if (!globalReset) begin
            last_grant <= GRANT_ALU;
        end else begin
            last_grant <= last_grant_next;
        end
    end

    always_comb begin
        cdb = '0;
        if (grant_br) begin
            cdb = br_head;
        end else if (grant_alu) begin
            cdb = alu_head;
        end
    end

    assign bus.cdbValid    = grant_alu | grant_br;
    assign bus.cdbRob      = cdb.rob;
    assign bus.cdbResult   = cdb.result;
    assign bus.cdbIsBranch = cdb.isBranch;
    assign bus.cdbAddress  = cdb.address;
    assign bus.cdbControl  = cdb.control;

endmodule
